eth_tx_clk_speed_ctrl: RTL

ETH_TX_CLK_SPEED_CTRL -- requirements
Module: eth_tx_clk_speed_ctrl

---
 rtl/eth_clk_pkg.sv | 55 +++++
 rtl/eth_clk_slot_gen.sv | 48 ++++
 rtl/eth_tx_clk_speed_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/eth_clk_pkg.sv
// Shared types and helpers for the Ethernet TX clock speed controller:
// speed codes, per-speed slot counts, FSM state encoding and slot pattern decode.
package eth_clk_pkg;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } speed_e;

    localparam logic [1:0] SPEED_ILLEGAL = 2'b11;

    localparam logic [5:0] SLOTS_10M      = 6'd50;
    localparam logic [5:0] SLOTS_100M     = 6'd5;
    localparam logic [5:0] SLOTS_1000M    = 6'd1;
    localparam logic [5:0] HIGH_SLOTS_10M = 6'd25;

    localparam logic [1:0] SLOT_LOW  = 2'b00;
    localparam logic [1:0] SLOT_HIGH = 2'b11;
    localparam logic [1:0] SLOT_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_GUARD = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    function automatic logic [5:0] slot_count(input speed_e s);
        logic [5:0] n;
        case (s)
            SPEED_10M:   n = SLOTS_10M;
            SPEED_100M:  n = SLOTS_100M;
            default:     n = SLOTS_1000M;
        endcase
        return n;
    endfunction

    // bit[0] is the first half of the slot, bit[1] the second half
    function automatic logic [1:0] slot_pattern(input speed_e s, input logic [5:0] slot);
        logic [1:0] p;
        case (s)
            SPEED_10M:  p = (slot < HIGH_SLOTS_10M) ? SLOT_HIGH : SLOT_LOW;
            SPEED_100M: begin
                case (slot)
                    6'd0, 6'd1: p = SLOT_HIGH;
                    6'd2:       p = SLOT_HALF;
                    default:    p = SLOT_LOW;
                endcase
            end
            default:    p = SLOT_HALF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/eth_clk_slot_gen.sv
// Slot counter and registered pattern output for one clock period of the active speed.
// The register always holds the slot value the clock-shift block will sample next.
module eth_clk_slot_gen
    import eth_clk_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       advance_i,
    input  logic       clear_i,
    input  logic       blank_i,
    input  speed_e     speed_i,
    input  speed_e     next_speed_i,
    output logic [5:0] slot_o,
    output logic       last_o,
    output logic [1:0] setting_o
);

    logic [5:0] slot_q, slot_d;
    logic [1:0] setting_q, setting_d;

    assign last_o = (slot_q == (slot_count(speed_i) - 6'd1));

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = 6'd0;
        end else if (advance_i) begin
            slot_d = last_o ? 6'd0 : slot_q + 6'd1;
        end
        // Decode against the speed that will be in force next cycle so a
        // guard-to-run hand-over presents slot 0 of the new speed immediately.
        setting_d = blank_i ? SLOT_LOW : slot_pattern(next_speed_i, slot_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q    <= 6'd0;
            setting_q <= SLOT_LOW;
        end else begin
            slot_q    <= slot_d;
            setting_q <= setting_d;
        end
    end

    assign slot_o    = slot_q;
    assign setting_o = setting_q;

endmodule

// File: rtl/eth_tx_clk_speed_ctrl.sv
// Ethernet TX clock speed controller: switches between 10M/100M/1000M slot patterns
// only at period boundaries with an idle MAC, inserting forced-low guard slots between speeds.
module eth_tx_clk_speed_ctrl
    import eth_clk_pkg::*;
#(
    parameter logic [1:0] reset_speed_p = 2'b10,
    parameter int         guard_slots_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] speed_i,
    input  logic       speed_v_i,
    output logic       speed_ready_o,
    output logic [1:0] speed_o,
    output logic       err_o,
    input  logic       tx_idle_i,
    output logic       tx_en_o,
    input  logic       osc_ready_i,
    output logic [1:0] clk_setting_o,
    output logic       period_start_o,
    output state_e     state_o
);

    localparam logic [3:0] GUARD_LAST = 4'(guard_slots_p - 1);
    localparam speed_e     RESET_SPEED = speed_e'(reset_speed_p);

    state_e     state_q, state_d;
    speed_e     speed_q, speed_d;
    speed_e     pending_q, pending_d;
    logic [3:0] guard_q, guard_d;
    logic       err_q, err_d;

    logic [5:0] slot;
    logic       slot_last;

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        pending_d = pending_q;
        guard_d   = guard_q;
        err_d     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (speed_v_i) begin
                    if (speed_i == SPEED_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (speed_i != speed_q) begin
                        pending_d = speed_e'(speed_i);
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave only once a whole period has been emitted and the MAC is quiet
                if (osc_ready_i && slot_last && tx_idle_i) begin
                    state_d = ST_GUARD;
                    guard_d = 4'd0;
                end
            end
            ST_GUARD: begin
                if (osc_ready_i) begin
                    if (guard_q == GUARD_LAST) begin
                        state_d = ST_RUN;
                        speed_d = pending_q;
                        guard_d = 4'd0;
                    end else begin
                        guard_d = guard_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_GUARD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_GUARD;
            speed_q   <= RESET_SPEED;
            pending_q <= RESET_SPEED;
            guard_q   <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            pending_q <= pending_d;
            guard_q   <= guard_d;
            err_q     <= err_d;
        end
    end

    eth_clk_slot_gen u_slot_gen (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .advance_i    (osc_ready_i && (state_q != ST_GUARD)),
        .clear_i      (state_q == ST_GUARD),
        .blank_i      (state_d == ST_GUARD),
        .speed_i      (speed_q),
        .next_speed_i (speed_d),
        .slot_o       (slot),
        .last_o       (slot_last),
        .setting_o    (clk_setting_o)
    );

    assign speed_ready_o  = (state_q == ST_RUN);
    assign tx_en_o        = (state_q == ST_RUN);
    assign speed_o        = speed_q;
    assign err_o          = err_q;
    assign period_start_o = osc_ready_i && (state_q == ST_RUN) && (slot == 6'd0);
    assign state_o        = state_q;

endmodule
